// File: rtl/tia_object_position_counter.sv
// tia_object_position_counter
// One object's 160-position horizontal counter. It advances on the visible
// motion clock (hblank low) or on an extra-clock strobe (ec_bar low), and it
// emits one-cycle start strobes for the main copy and the NUSIZ duplicates.
// Optional feature macro: TIA_OBJECT_POSITION_COUNTER_COPIES_EN enables the
// NUSIZ duplicate-copy decode. When the macro is undefined, start_copy is
// held at 0 and nusiz is ignored.
module tia_object_position_counter #(
  parameter int COUNT_MAX  = 160,
  parameter int RESET_LOAD = 0
) (
  input  logic       clk,
  input  logic       r,
  input  logic       hblank,
  input  logic       ec_bar,
  input  logic       resp,
  input  logic [2:0] nusiz,
  output logic [7:0] pos,
  output logic       start,
  output logic       start_copy
);

  localparam logic [7:0] LP_LAST = 8'(COUNT_MAX - 1);
  localparam logic [7:0] LP_LOAD = 8'(RESET_LOAD);

  logic [7:0] r_pos;
  logic       r_start;
  logic       r_start_copy;
  logic       w_adv;
  logic [7:0] w_nxt;
  logic       w_copy_hit;

`ifdef TIA_OBJECT_POSITION_COUNTER_COPIES_EN
  function automatic logic copy_hit(input logic [2:0] sel, input logic [7:0] v);
    case (sel)
      3'b001:  copy_hit = (v == 8'd16);
      3'b010:  copy_hit = (v == 8'd32);
      3'b011:  copy_hit = (v == 8'd16) || (v == 8'd32);
      3'b100:  copy_hit = (v == 8'd64);
      3'b110:  copy_hit = (v == 8'd32) || (v == 8'd64);
      default: copy_hit = 1'b0;
    endcase
  endfunction

  assign w_copy_hit = copy_hit(nusiz, w_nxt);
`else
  // Duplicate copies are not drawn in this build; nusiz is deliberately unused.
  logic w_unused_nusiz;
  assign w_unused_nusiz = ^nusiz;
  assign w_copy_hit     = 1'b0;
`endif

  // Motion clock and extra clock are OR-ed: both together still give one step.
  assign w_adv = ~hblank | ~ec_bar;
  assign w_nxt = (r_pos == LP_LAST) ? 8'd0 : r_pos + 8'd1;

  // Counter and start strobes, priority r > resp > advance > hold.
  always_ff @(posedge clk) begin
    if (r) begin
      r_pos        <= 8'd0;
      r_start      <= 1'b0;
      r_start_copy <= 1'b0;
    end else if (resp) begin
      r_pos        <= LP_LOAD;
      r_start      <= 1'b0;
      r_start_copy <= 1'b0;
    end else if (w_adv) begin
      r_pos        <= w_nxt;
      r_start      <= (w_nxt == 8'd0);
      r_start_copy <= w_copy_hit;
    end else begin
      r_start      <= 1'b0;
      r_start_copy <= 1'b0;
    end
  end

  assign pos        = r_pos;
  assign start      = r_start;
  assign start_copy = r_start_copy;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Testbench for tia_object_position_counter: a line-position model checked
// every cycle, plus directed scenarios with hand-computed totals.
module tb_tia_object_position_counter;

  logic       clk = 1'b0;
  logic       r, hblank, ec_bar, resp;
  logic [2:0] nusiz;
  logic [7:0] pos;
  logic       start, start_copy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  int m_pos   = 0;
  bit m_start = 1'b0;
  bit m_copy  = 1'b0;

  tia_object_position_counter #(.COUNT_MAX(160), .RESET_LOAD(0)) dut (
    .clk(clk), .r(r), .hblank(hblank), .ec_bar(ec_bar), .resp(resp),
    .nusiz(nusiz), .pos(pos), .start(start), .start_copy(start_copy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Duplicate-copy positions listed per NUSIZ value.
  function automatic bit m_is_copy(input int ns, input int v);
`ifdef TIA_OBJECT_POSITION_COUNTER_COPIES_EN
    case (ns)
      1: return v == 16;
      2: return v == 32;
      3: return v == 16 || v == 32;
      4: return v == 64;
      6: return v == 32 || v == 64;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: a position on a 160-wide line plus arrival events.
  always @(posedge clk) begin
    if (r) begin
      m_pos = 0; m_start = 0; m_copy = 0;
    end else if (resp) begin
      m_pos = 0; m_start = 0; m_copy = 0;
    end else if (!hblank || !ec_bar) begin
      m_pos   = (m_pos + 1) % 160;
      m_start = (m_pos == 0);
      m_copy  = m_is_copy(int'(nusiz), m_pos);
    end else begin
      m_start = 0; m_copy = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pos", int'(pos), m_pos);
      chk("start", int'(start), int'(m_start));
      chk("start_copy", int'(start_copy), int'(m_copy));
    end
  end

  int n_start, n_copy, copy_sum, wait_n;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (start) n_start++;
      if (start_copy) begin n_copy++; copy_sum += int'(pos); end
    end
  endtask

  task automatic clr();
    n_start = 0; n_copy = 0; copy_sum = 0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ec_bar = 1'b0; run(1);
      ec_bar = 1'b1; run(1);
    end
  endtask

  initial begin
    r = 1'b1; hblank = 1'b1; ec_bar = 1'b1; resp = 1'b0; nusiz = 3'b000;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("reset_pos", int'(pos), 0);
    chk("reset_start", int'(start), 0);
    chk("reset_copy", int'(start_copy), 0);

    // free run, two lines
    r = 1'b0; hblank = 1'b0; clr();
    run(320);
    chk("freerun_starts", n_start, 2);
    chk("freerun_copies", n_copy, 0);
    chk("freerun_pos", int'(pos), 0);

    // reach 40, then freeze in blank and apply extra clocks
    run(40);
    hblank = 1'b1; clr();
    chk("blank_pos40", int'(pos), 40);
    pulses(15);
    chk("ec15_pos", int'(pos), 55);
    pulses(8);
    chk("ec8_pos", int'(pos), 63);
    chk("ec_strobes", n_start + n_copy, 0);
    resp = 1'b1; run(1); resp = 1'b0;
    ec_bar = 1'b0; run(40); ec_bar = 1'b1;
    run(10);
    chk("ec0_pos", int'(pos), 40);

    // simultaneous advance sources
    resp = 1'b1; run(1); resp = 1'b0;
    hblank = 1'b0; ec_bar = 1'b0; run(10);
    chk("both_pos", int'(pos), 10);
    ec_bar = 1'b1;

    // position reset at 100
    run(90);
    chk("pre_resp_pos", int'(pos), 100);
    resp = 1'b1; run(1); resp = 1'b0;
    chk("resp_pos", int'(pos), 0);
    chk("resp_start", int'(start), 0);
    wait_n = 0;
    do begin
      @(negedge clk); wait_n++;
    end while (!start && wait_n < 400);
    chk("resp_next_start", wait_n, 160);

    // resp together with r
    r = 1'b1; resp = 1'b1; run(1); r = 1'b0; resp = 1'b0; hblank = 1'b1;
    chk("r_resp_pos", int'(pos), 0);
    chk("r_resp_strobes", int'(start) + int'(start_copy), 0);

    // copies
    hblank = 1'b0; nusiz = 3'b011; clr(); run(160);
    chk("n011_starts", n_start, 1);
`ifdef TIA_OBJECT_POSITION_COUNTER_COPIES_EN
    chk("n011_copies", n_copy, 2);
    chk("n011_copy_sum", copy_sum, 48);
`else
    chk("n011_copies", n_copy, 0);
`endif
    nusiz = 3'b110; clr(); run(160);
`ifdef TIA_OBJECT_POSITION_COUNTER_COPIES_EN
    chk("n110_copies", n_copy, 2);
    chk("n110_copy_sum", copy_sum, 96);
`else
    chk("n110_copies", n_copy, 0);
`endif
    nusiz = 3'b101; clr(); run(160);
    chk("n101_copies", n_copy, 0);
    chk("n101_starts", n_start, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
